// File: rtl/game_timer_ctrl.sv
// Round countdown timer: prescaled tick, round-robin miss penalties, and a
// run/pause/fail/done sequencer.
module game_timer_ctrl #(
   parameter int TICK_DIV   = 5000,
   parameter int START_TIME = 1800000,
   parameter int PENALTY    = 10000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        stop,
   input  logic [3:0]  miss_req,
   output logic [3:0]  miss_ack,
   output logic [20:0] time_left,
   output logic        tick,
   output logic [2:0]  state,
   output logic        fail,
   output logic        done
);

   // state | meaning
   // IDLE  | no round yet; waiting for start
   // RUN   | counting down, penalties granted
   // PAUSE | countdown and prescaler frozen, misses still latched
   // FAIL  | time ran out
   // DONE  | round cleared by stop
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      FAIL  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_t        state_q;
   logic [PW-1:0] presc;
   logic [3:0]    pend;
   logic [1:0]    ptr;

   logic          grant_valid;
   logic [1:0]    grant_idx;
   logic [1:0]    idx;
   logic [3:0]    grant_onehot;
   logic          tick_now;
   logic [22:0]   dec;
   logic [22:0]   cur;
   logic [20:0]   time_sat;

   // Round-robin search from the pointer over the registered pending flags.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr;
      idx         = ptr;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!grant_valid && pend[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   assign grant_onehot = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
   assign tick_now     = (presc == PRESC_LAST);

   // Widened so the combined decrement can be compared before it underflows.
   assign dec      = 23'(tick_now) + (grant_valid ? 23'(PENALTY) : 23'd0);
   assign cur      = {2'b00, time_left};
   assign time_sat = (dec >= cur) ? 21'd0 : 21'(cur - dec);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         time_left <= 21'(START_TIME);
         presc     <= '0;
         pend      <= 4'b0000;
         ptr       <= 2'd0;
         miss_ack  <= 4'b0000;
         tick      <= 1'b0;
      end else begin
         miss_ack <= 4'b0000;
         tick     <= 1'b0;
         case (state_q)
            IDLE, FAIL, DONE: begin
               if (start) begin
                  state_q   <= RUN;
                  time_left <= 21'(START_TIME);
                  presc     <= '0;
                  pend      <= 4'b0000;
                  ptr       <= 2'd0;
               end
            end
            RUN: begin
               if (stop) begin
                  state_q <= DONE;
                  pend    <= 4'b0000;
               end else begin
                  time_left <= time_sat;
                  tick      <= tick_now;
                  miss_ack  <= grant_onehot;
                  presc     <= tick_now ? '0 : presc + PW'(1);
                  if (grant_valid)
                     ptr <= grant_idx + 2'd1;
                  if (time_sat == 21'd0) begin
                     state_q <= FAIL;
                     pend    <= 4'b0000;
                  end else begin
                     pend <= (pend & ~grant_onehot) | miss_req;
                     if (pause)
                        state_q <= PAUSE;
                  end
               end
            end
            PAUSE: begin
               if (stop) begin
                  state_q <= DONE;
                  pend    <= 4'b0000;
               end else begin
                  pend <= pend | miss_req;
                  if (pause)
                     state_q <= RUN;
               end
            end
            default: begin
               state_q <= IDLE;
               pend    <= 4'b0000;
            end
         endcase
      end
   end

   assign state = state_q;
   assign fail  = (state_q == FAIL);
   assign done  = (state_q == DONE);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl: stimulus queues the expected output
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_game_timer_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start, pause, stop;
   logic [3:0]  miss_req;
   logic [3:0]  miss_ack;
   logic [20:0] time_left;
   logic        tick;
   logic [2:0]  state;
   logic        fail, done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  ack;
      logic        tk;
      logic [20:0] tl;
      logic [2:0]  st;
   } exp_t;

   exp_t       exp_q[$];
   logic [2:0] prev_state = 3'd0;

   game_timer_ctrl #(.TICK_DIV(4), .START_TIME(20), .PENALTY(5)) dut (
      .clock(clock), .reset(reset), .start(start), .pause(pause), .stop(stop),
      .miss_req(miss_req), .miss_ack(miss_ack), .time_left(time_left),
      .tick(tick), .state(state), .fail(fail), .done(done)
   );

   always #5 clock = ~clock;

   task automatic push(input logic [3:0] a, input logic t, input int tl, input int st);
      exp_t e;
      e.ack = a;
      e.tk  = t;
      e.tl  = 21'(tl);
      e.st  = 3'(st);
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // An output event is any tick, any ack, or any state change.
   always @(negedge clock) begin
      if (tick || miss_ack != 4'b0000 || state != prev_state) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event at %0t: ack=%b tick=%b time_left=%0d state=%0d",
                     $time, miss_ack, tick, time_left, state);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (miss_ack !== e.ack || tick !== e.tk || time_left !== e.tl || state !== e.st ||
                fail !== (e.st == 3'd3) || done !== (e.st == 3'd4)) begin
               n_bad++;
               $display("FAIL event at %0t: got ack=%b tick=%b tl=%0d st=%0d fail=%b done=%b, expected ack=%b tick=%b tl=%0d st=%0d",
                        $time, miss_ack, tick, time_left, state, fail, done, e.ack, e.tk, e.tl, e.st);
            end
         end
      end
      prev_state = state;
   end

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; miss_req = 4'b0000;
      step(2);
      chk("reset_time_left", int'(time_left), 20);
      chk("reset_state", int'(state), 0);
      chk("reset_flags", int'({fail, done, tick}), 0);
      chk("reset_ack", int'(miss_ack), 0);
      reset = 1'b0;
      step(1);

      // Free-running countdown to FAIL: one tick every 4 cycles.
      start = 1'b1; push(4'b0000, 1'b0, 20, 1); step(1); start = 1'b0;
      for (int k = 1; k <= 20; k++)
         push(4'b0000, 1'b1, 20 - k, (k == 20) ? 3 : 1);
      step(80);
      chk("countdown_fail", int'(fail), 1);
      chk("countdown_state", int'(state), 3);
      chk("countdown_time", int'(time_left), 0);
      miss_req = 4'b1111; step(1); miss_req = 4'b0000;
      step(3);

      // All four misses at once: acks rotate 0..3, saturating into FAIL.
      start = 1'b1; push(4'b0000, 1'b0, 20, 1); step(1); start = 1'b0;
      miss_req = 4'b1111; step(1); miss_req = 4'b0000;
      push(4'b0001, 1'b0, 15, 1);
      push(4'b0010, 1'b0, 10, 1);
      push(4'b0100, 1'b1, 4, 1);
      push(4'b1000, 1'b0, 0, 3);
      step(4);
      step(2);

      // Miss latched in PAUSE, granted once running; prescaler resumes.
      start = 1'b1; push(4'b0000, 1'b0, 20, 1); step(1); start = 1'b0;
      pause = 1'b1; push(4'b0000, 1'b0, 20, 2); step(1); pause = 1'b0;
      miss_req = 4'b0100; step(1); miss_req = 4'b0000;
      step(2);
      pause = 1'b1; push(4'b0000, 1'b0, 20, 1); step(1); pause = 1'b0;
      push(4'b0100, 1'b0, 15, 1);
      push(4'b0000, 1'b1, 14, 1);
      step(3);
      step(1);

      // Stop wins over pause; restart reloads the full time.
      stop = 1'b1; pause = 1'b1; push(4'b0000, 1'b0, 14, 4); step(1);
      stop = 1'b0; pause = 1'b0;
      chk("stop_done", int'(done), 1);
      chk("stop_time", int'(time_left), 14);
      start = 1'b1; push(4'b0000, 1'b0, 20, 1); step(1); start = 1'b0;
      chk("restart_time", int'(time_left), 20);

      // Walk time_left down to 3, then a grant on a tick cycle saturates to 0.
      miss_req = 4'b0011; step(1); miss_req = 4'b0000;
      push(4'b0001, 1'b0, 15, 1);
      push(4'b0010, 1'b0, 10, 1);
      push(4'b0000, 1'b1, 9, 1);
      step(3);
      miss_req = 4'b0100; step(1); miss_req = 4'b0000;
      push(4'b0100, 1'b0, 4, 1);
      push(4'b0000, 1'b1, 3, 1);
      step(3);
      step(2);
      miss_req = 4'b1000; step(1); miss_req = 4'b0000;
      push(4'b1000, 1'b1, 0, 3);
      step(1);
      chk("sat_fail", int'(fail), 1);
      chk("sat_time", int'(time_left), 0);
      miss_req = 4'b0001; step(1); miss_req = 4'b0000;
      step(3);

      // Reset with three misses pending: nothing is granted after restart.
      start = 1'b1; push(4'b0000, 1'b0, 20, 1); step(1); start = 1'b0;
      miss_req = 4'b0111; step(1); miss_req = 4'b0000;
      #1 reset = 1'b1; push(4'b0000, 1'b0, 20, 0);
      #1;
      chk("async_reset_state", int'(state), 0);
      chk("async_reset_time", int'(time_left), 20);
      chk("async_reset_outs", int'({miss_ack, tick, fail, done}), 0);
      step(2);
      reset = 1'b0;
      start = 1'b1; push(4'b0000, 1'b0, 20, 1); step(1); start = 1'b0;
      step(3);
      stop = 1'b1; push(4'b0000, 1'b0, 20, 4); step(1); stop = 1'b0;
      step(5);

      chk("events_outstanding", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 5000: clocks per countdown tick, minimum 2.
REQ-002 The block SHALL have parameter START_TIME, default 1800000: value loaded into time_left at round start.
REQ-003 The block SHALL have parameter PENALTY, default 10000: ticks removed per serviced miss.
REQ-004 The block SHALL have port: clock  input  1  system clock; all logic on the rising edge.
REQ-005 The block SHALL have port: reset  input  1  asynchronous, active-high.
REQ-006 The block SHALL have port: start  input  1  single-cycle pulse that begins a round.
REQ-007 The block SHALL have port: pause  input  1  single-cycle pulse that toggles between RUN and PAUSE.
REQ-008 The block SHALL have port: stop  input  1  single-cycle pulse that ends a round as cleared.
REQ-009 The block SHALL have port: miss_req  input  4  per-requester miss pulses.
REQ-010 The block SHALL have port: miss_ack  output  4  one-hot, one-cycle pulse in the cycle a requester's penalty is applied.
REQ-011 The block SHALL have port: time_left  output  21  remaining ticks.
REQ-012 The block SHALL have port: tick  output  1  one-cycle pulse in each cycle a tick is applied.
REQ-013 The block SHALL have port: state  output  3  current FSM state encoding.
REQ-014 The block SHALL have port: fail  output  1  high while state is FAIL.
REQ-015 The block SHALL have port: done  output  1  high while state is DONE.

Function
REQ-016 The FSM SHALL have states IDLE=0, RUN=1, PAUSE=2, FAIL=3, DONE=4; all other encodings SHALL go to IDLE on the next clock.
REQ-017 In IDLE, FAIL or DONE, a start pulse SHALL in one edge: load START_TIME, clear the prescaler, clear all pending flags, set the arbiter pointer to 0, and enter RUN.
REQ-018 A start pulse in RUN or PAUSE SHALL be ignored.
REQ-019 Input priority in RUN/PAUSE SHALL be stop > pause; stop SHALL enter DONE with time_left frozen and no tick or penalty applied that cycle.
REQ-020 A pause pulse SHALL move RUN->PAUSE or PAUSE->RUN; in PAUSE the prescaler and time_left SHALL hold.
REQ-021 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, wrapping to 0; tick SHALL pulse in the RUN cycle where the count equals TICK_DIV-1.
REQ-022 A miss_req bit SHALL set its pending flag in RUN or PAUSE, and SHALL be ignored in IDLE, FAIL and DONE.
REQ-023 A miss_req on a source whose flag is already pending SHALL merge into that flag, with no extra penalty.
REQ-024 The arbiter SHALL be round-robin, granting at most one pending source per RUN cycle.
REQ-025 Arbiter search SHALL start at the pointer; after a grant to source k, the pointer SHALL become (k+1) mod 4.
REQ-026 When a source is granted, its pending flag SHALL clear and its miss_ack bit SHALL pulse that cycle.
REQ-027 A request arriving in the same cycle its flag clears SHALL set the flag again.
REQ-028 Per RUN cycle, time_left SHALL lose (tick?1:0) + (grant?PENALTY:0), saturating at 0; there SHALL be no wrap-around below 0.
REQ-029 If the new time_left value is 0 while in RUN, the FSM SHALL enter FAIL on that same edge; this check SHALL take priority over pause.
REQ-030 In FAIL, DONE and IDLE, time_left SHALL hold and miss_ack, tick and pending flags SHALL stay 0.
REQ-031 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from any input to any output.
REQ-032 time_left arithmetic SHALL use at least 22 bits internally so the subtraction cannot overflow before saturation.

Reset
REQ-033 Asserting reset SHALL, asynchronously: set state to IDLE, time_left to START_TIME, prescaler, pending flags and pointer to 0, and miss_ack, tick, fail and done to 0.
REQ-034 Reset asserted mid-round SHALL discard all pending misses; the first start after reset release SHALL behave as REQ-017.

Verification
REQ-035 Parameters TICK_DIV=4, START_TIME=20, PENALTY=5; start, then run 80 clocks -> tick every 4th cycle; time_left reaches 0 and fail=1 after exactly 20 ticks; state=3.
REQ-036 miss_req=4'b1111 in one RUN cycle -> acks 0001, 0010, 0100, 1000 on 4 consecutive cycles; time_left drops by 20 plus any ticks in those cycles.
REQ-037 miss_req=4'b0100 while in PAUSE, then pause again -> no ack in PAUSE; ack=0100 in the first RUN cycle; time_left -5; prescaler resumes from its held value.
REQ-038 time_left=3, a miss is granted in a tick cycle -> time_left=0 (saturated) and FAIL on the same edge; a later miss_req gives no ack.
REQ-039 stop and pause in the same RUN cycle -> DONE, done=1, time_left unchanged; a later start -> RUN with time_left=20.
REQ-040 reset asserted while 3 misses are pending -> outputs at reset values immediately; after release and start, no miss_ack occurs.
